// File: rtl/ipc_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ipc_link_pkg
//  Description : Shared types and constants for the IPC comdata link
//                controller: link state encoding, XEDS nibble bit positions
//                and the default watchdog length.
//  Revision    : 1.0 - initial release
// ============================================================================
package ipc_link_pkg;

    // Default number of ce ticks a transfer may stall before it is aborted
    localparam int c_TIMEOUT_TICKS_DEFAULT = 4096;

    // Bit positions inside the host XEDS nibble
    localparam int c_XEDS_START = 0;
    localparam int c_XEDS_DATA  = 1;
    localparam int c_XEDS_STOP  = 2;
    localparam int c_XEDS_XSTOP = 3;

    // Value loaded into the remaining-bit counter by a host write
    localparam logic [1:0] c_CNT_LOAD = 2'd2;

    // Link state: ARMED has two falls outstanding, SHIFT has one
    typedef enum logic [1:0] {
        c_ST_IDLE  = 2'd0,
        c_ST_ARMED = 2'd1,
        c_ST_SHIFT = 2'd2
    } link_state_t;

endpackage : ipc_link_pkg
`default_nettype wire

// File: rtl/ipc_link_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : ipc_link_wdog
//  Description : Transfer watchdog. Counts ce ticks while the link is busy,
//                restarts on every comctrl fall or host write, and flags
//                expiry on the tick that would take the count past
//                TIMEOUT_TICKS-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module ipc_link_wdog
    import ipc_link_pkg::*;
#(
    parameter int TIMEOUT_TICKS = c_TIMEOUT_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic busy,
    input  logic clear,
    output logic expire
);

    localparam int               c_W    = (TIMEOUT_TICKS > 2) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [c_W-1:0]   c_LAST = c_W'(TIMEOUT_TICKS - 1);

    logic [c_W-1:0] r_count;
    logic           w_at_last;

    assign w_at_last = (r_count == c_LAST);
    // Activity in the same cycle always wins over expiry
    assign expire    = busy & ce & ~clear & w_at_last;

    // Tick counter: held at zero while idle or whenever the link shows activity
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (!busy || clear) begin
            r_count <= '0;
        end else if (ce) begin
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

endmodule : ipc_link_wdog
`default_nettype wire

// File: rtl/ipc_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ipc_link_ctrl
//  Description : Host-to-IPC comdata shift link. A host write loads a 4-bit
//                XEDS nibble; each falling edge of the IPC shift clock
//                (comctrl) moves it one place towards bit0, which drives the
//                comdata line. busy covers the two falls of a transfer.
//                Optional build macro IPC_LINK_TIMEOUT_EN adds a ce-tick
//                watchdog that aborts a stalled transfer and sets timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module ipc_link_ctrl
    import ipc_link_pkg::*;
#(
    parameter int TIMEOUT_TICKS = c_TIMEOUT_TICKS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       wr_stb,
    input  logic [3:0] wr_data,
    input  logic       comctrl,
    input  logic       comdata_from_ipc,
    output logic       comdata_to_ipc,
    output logic       host_comdata,
    output logic       busy,
    output logic       timeout
);

    link_state_t r_state;
    logic [3:0]  r_sr;
    logic [1:0]  r_cnt;
    logic        r_comctrl_q;
    logic        r_busy;
    logic        r_timeout;
    logic        w_fall;
    logic        w_expire;

    // comctrl is generated in the clk domain, so a plain delayed copy suffices
    assign w_fall = r_comctrl_q & ~comctrl;

`ifdef IPC_LINK_TIMEOUT_EN
    ipc_link_wdog #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .ce     (ce),
        .busy   (r_busy),
        .clear  (wr_stb | w_fall),
        .expire (w_expire)
    );
`else
    logic w_unused;
    assign w_expire = 1'b0;
    // ce and the watchdog length have no function without the watchdog
    assign w_unused = &{1'b0, ce, (TIMEOUT_TICKS > 0)};
`endif

    // Link state machine: host write restarts, watchdog aborts, falls shift
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_sr        <= 4'd0;
            r_cnt       <= 2'd0;
            r_comctrl_q <= 1'b0;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_comctrl_q <= comctrl;
            if (wr_stb) begin
                // A coincident fall is dropped; unsent bits are discarded
                r_sr      <= wr_data;
                r_cnt     <= c_CNT_LOAD;
                r_state   <= c_ST_ARMED;
                r_busy    <= 1'b1;
                r_timeout <= 1'b0;
            end else if (w_expire) begin
                r_cnt     <= 2'd0;
                r_state   <= c_ST_IDLE;
                r_busy    <= 1'b0;
                r_timeout <= 1'b1;
            end else if (w_fall) begin
                // Shifting continues with zero fill even when idle
                r_sr <= {1'b0, r_sr[3:1]};
                case (r_state)
                    c_ST_ARMED: begin
                        r_cnt   <= 2'd1;
                        r_state <= c_ST_SHIFT;
                        r_busy  <= 1'b1;
                    end
                    c_ST_SHIFT: begin
                        r_cnt   <= 2'd0;
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_cnt   <= 2'd0;
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign comdata_to_ipc = r_sr[0];
    // Open-drain style line: either side can pull comdata low
    assign host_comdata   = r_sr[0] & comdata_from_ipc;
    assign busy           = r_busy;
`ifdef IPC_LINK_TIMEOUT_EN
    assign timeout        = r_timeout;
`else
    assign timeout        = 1'b0;
`endif

endmodule : ipc_link_ctrl
`default_nettype wire
